// File: rtl/btn_conditioner.sv
// Push-button and slide-switch conditioner: 2-flop synchronizers, per-button
// debounce with press/release/auto-repeat pulses, and a vector switch debouncer.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BTN-1:0]    btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic [N_BTN-1:0]    btn_release,
  output logic [N_BTN-1:0]    btn_repeat,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic                sw_changed
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_FULL   = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

  logic [N_BTN-1:0]    btn_s1, btn_s2;
  logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic          level_q, press_q, release_q, repeat_q, repeat_nx;
    logic [DW-1:0] db_cnt;
    logic          flip, rise, fall;
    rpt_state_t    state, state_nx;
    logic [RW-1:0] rpt_cnt, rpt_cnt_nx;

    assign flip = (btn_s2[i] != level_q) && (db_cnt == DB_LAST);
    assign rise = flip && !level_q;
    assign fall = flip && level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_cnt    <= '0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        if (btn_s2[i] == level_q) begin
          db_cnt <= '0;
        end else if (flip) begin
          level_q <= ~level_q;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        rpt_cnt  <= '0;
        repeat_q <= 1'b0;
      end else begin
        state    <= state_nx;
        rpt_cnt  <= rpt_cnt_nx;
        repeat_q <= repeat_nx;
      end
    end

    // Debounce edges drive the FSM directly so HOLD starts in the press cycle
    // and a release always wins over a simultaneously expiring count.
    always_comb begin
      state_nx   = state;
      rpt_cnt_nx = rpt_cnt;
      repeat_nx  = 1'b0;
      if (fall) begin
        state_nx   = IDLE;
        rpt_cnt_nx = '0;
      end else if (rise) begin
        state_nx   = HOLD;
        rpt_cnt_nx = '0;
      end else begin
        case (state)
          HOLD: begin
            if (rpt_cnt == HOLD_LAST) begin
              repeat_nx  = 1'b1;
              state_nx   = RPT;
              rpt_cnt_nx = '0;
            end else begin
              rpt_cnt_nx = rpt_cnt + 1'b1;
            end
          end
          RPT: begin
            if (rpt_cnt == RPT_LAST) begin
              repeat_nx  = 1'b1;
              rpt_cnt_nx = '0;
            end else begin
              rpt_cnt_nx = rpt_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

  // The cycle in which a new vector first appears counts as its first stable
  // cycle, keeping switch latency equal to button latency.
  logic [DW-1:0] sw_cnt, sw_cnt_inc;

  assign sw_cnt_inc = (sw_s2 != sw_prev) ? DW'(1) : sw_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev    <= '0;
      sw_cnt     <= '0;
      sw_sync    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_prev    <= sw_s2;
      sw_changed <= 1'b0;
      if (sw_s2 == sw_sync) begin
        sw_cnt <= '0;
      end else if (sw_cnt_inc == DB_FULL) begin
        sw_sync    <= sw_s2;
        sw_changed <= 1'b1;
        sw_cnt     <= '0;
      end else begin
        sw_cnt <= sw_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random stimulus checked
// each cycle against a window-based reference model of debounce and repeat.
module tb_btn_conditioner;
  localparam int NB = 5;
  localparam int SW = 16;
  localparam int D  = 4;
  localparam int H  = 20;
  localparam int R  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [SW-1:0] sw_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [SW-1:0] sw_sync;
  logic          sw_changed;

  btn_conditioner #(
    .N_BTN(NB), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .sw_sync(sw_sync), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int e      = 0;

  // Reference model: raw samples per edge; a level flips when the D samples
  // that have passed the synchronizer all disagree with it.
  logic [NB-1:0] bh [0:D+1];
  logic [SW-1:0] sh [0:D+1];
  logic [NB-1:0] m_level, x_press, x_release, x_repeat;
  logic [SW-1:0] m_sync;
  logic          x_swch;
  int            m_press_edge [NB];

  int n_press [NB], n_rel [NB], n_rep [NB];
  int last_press [NB], last_rel [NB], first_rep [NB];
  int n_swch, swch_edge;
  int rep_off [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= D + 1; j++) begin
      bh[j] = '0;
      sh[j] = '0;
    end
    m_level = '0;
    m_sync  = '0;
  endtask

  task automatic clr_tally();
    for (int i = 0; i < NB; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0;
      last_press[i] = -1000; last_rel[i] = -1000; first_rep[i] = -1000;
    end
    n_swch = 0;
    swch_edge = -1000;
    rep_off.delete();
  endtask

  task automatic tick();
    logic all_d, all_s;
    int   d;
    @(posedge clk);
    e++;
    for (int j = D + 1; j > 0; j--) begin
      bh[j] = bh[j-1];
      sh[j] = sh[j-1];
    end
    bh[0] = btn_raw;
    sh[0] = sw_raw;
    x_press = '0; x_release = '0; x_repeat = '0; x_swch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      all_d = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (bh[j][i] == m_level[i]) all_d = 1'b0;
      if (all_d) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          x_press[i] = 1'b1;
          m_press_edge[i] = e;
        end else begin
          x_release[i] = 1'b1;
        end
      end else if (m_level[i]) begin
        d = e - m_press_edge[i];
        if (d >= H && (d - H) % R == 0) x_repeat[i] = 1'b1;
      end
    end
    all_s = 1'b1;
    for (int j = 3; j <= D + 1; j++)
      if (sh[j] != sh[2]) all_s = 1'b0;
    if (all_s && sh[2] != m_sync) begin
      m_sync = sh[2];
      x_swch = 1'b1;
    end
    #1;
    chk("btn_level",   32'(btn_level),   32'(m_level));
    chk("btn_press",   32'(btn_press),   32'(x_press));
    chk("btn_release", 32'(btn_release), 32'(x_release));
    chk("btn_repeat",  32'(btn_repeat),  32'(x_repeat));
    chk("sw_sync",     32'(sw_sync),     32'(m_sync));
    chk("sw_changed",  32'(sw_changed),  32'(x_swch));
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i])   begin n_press[i]++; last_press[i] = e; end
      if (btn_release[i]) begin n_rel[i]++;   last_rel[i]   = e; end
      if (btn_repeat[i]) begin
        if (n_rep[i] == 0) first_rep[i] = e;
        n_rep[i]++;
        if (i == 1) rep_off.push_back(e - last_press[1]);
      end
    end
    if (sw_changed) begin n_swch++; swch_edge = e; end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called just after a sampling point; asserts reset between edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level",   32'(btn_level),   32'd0);
    chk("rst_press",   32'(btn_press),   32'd0);
    chk("rst_release", 32'(btn_release), 32'd0);
    chk("rst_repeat",  32'(btn_repeat),  32'd0);
    chk("rst_sw_sync", 32'(sw_sync),     32'd0);
    chk("rst_sw_chg",  32'(sw_changed),  32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  int            settle;
  logic [NB-1:0] seen;

  initial begin
    model_reset();
    clr_tally();
    reset_pulse();
    ticks(8);

    // Bounce on button 0, then settle high
    clr_tally();
    for (int c = 0; c < 12; c++) begin
      btn_raw[0] = ((c / 2) % 2 == 0);
      tick();
    end
    btn_raw[0] = 1'b1;
    settle = e + 1;
    ticks(12);
    chk("bounce_presses", 32'(n_press[0]), 32'd1);
    chk("bounce_releases", 32'(n_rel[0]), 32'd0);
    chk("bounce_latency", 32'(last_press[0] - settle + 1), 32'd6);
    btn_raw[0] = 1'b0;
    ticks(10);

    // Three-cycle glitch on button 2
    clr_tally();
    btn_raw[2] = 1'b1;
    ticks(3);
    btn_raw[2] = 1'b0;
    ticks(10);
    chk("glitch_press", 32'(n_press[2]), 32'd0);
    chk("glitch_release", 32'(n_rel[2]), 32'd0);

    // Long hold on button 1: level high for 60 cycles
    clr_tally();
    btn_raw[1] = 1'b1;
    ticks(60);
    btn_raw[1] = 1'b0;
    ticks(15);
    chk("hold_press", 32'(n_press[1]), 32'd1);
    chk("hold_release", 32'(n_rel[1]), 32'd1);
    chk("hold_len", 32'(last_rel[1] - last_press[1]), 32'd60);
    chk("hold_nrep", 32'(rep_off.size()), 32'd5);
    for (int j = 0; j < rep_off.size() && j < 5; j++)
      chk("hold_rep_offset", 32'(rep_off[j]), 32'(20 + 8 * j));

    // Simultaneous press on buttons 0 and 4
    clr_tally();
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    seen = '0;
    for (int k = 0; k < 20 && seen == '0; k++) begin
      tick();
      seen = btn_press;
    end
    chk("simul_press", 32'(seen), 32'h11);
    btn_raw[0] = 1'b0;
    btn_raw[4] = 1'b0;
    ticks(10);

    // Switch vector update
    clr_tally();
    sw_raw = 16'hA5C3;
    settle = e + 1;
    ticks(12);
    chk("sw_nchg", 32'(n_swch), 32'd1);
    chk("sw_latency", 32'(swch_edge - settle + 1), 32'd6);
    chk("sw_value", 32'(sw_sync), 32'hA5C3);

    // Reset while button 3 is auto-repeating, held through reset
    btn_raw[3] = 1'b1;
    ticks(30);
    chk("pre_rst_state", 32'(n_rep[3] > 0), 32'd1);
    reset_pulse();
    clr_tally();
    settle = e + 1;
    ticks(30);
    chk("rst_press_count", 32'(n_press[3]), 32'd1);
    chk("rst_press_latency", 32'(last_press[3] - settle + 1), 32'd6);
    chk("rst_first_repeat", 32'(first_rep[3] - last_press[3]), 32'd20);
    chk("rst_sw_redetect", 32'(n_swch), 32'd1);
    btn_raw[3] = 1'b0;
    ticks(10);

    // Random stimulus with one mid-run reset
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 29) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) sw_raw = 16'($urandom);
        else sw_raw[$urandom_range(0, SW - 1)] ^= 1'b1;
      end
      if (k == 800) reset_pulse();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of push-buttons (bit order [4]=BTNU, [3]=BTND, [2]=BTNL, [1]=BTNR, [0]=BTNC).
REQ-002 SHALL have parameter SW_WIDTH, default 16, slide-switch bus width.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 2000000, stable cycles required before accepting a change (20 ms at 100 MHz); legal range >=1.
REQ-004 SHALL have parameter HOLD_CYCLES, default 50000000, cycles from press to first auto-repeat; legal range >=1.
REQ-005 SHALL have parameter REPEAT_CYCLES, default 10000000, cycles between subsequent auto-repeats; legal range >=1.
REQ-006 clk  input  1  system clock, 100 MHz.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 btn_raw  input  N_BTN  asynchronous pad inputs from the buttons, active-high.
REQ-009 sw_raw  input  SW_WIDTH  asynchronous pad inputs from the switches.
REQ-010 btn_level  output  N_BTN  debounced button state.
REQ-011 btn_press  output  N_BTN  one-cycle pulse on each debounced rising edge.
REQ-012 btn_release  output  N_BTN  one-cycle pulse on each debounced falling edge.
REQ-013 btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while a button is held.
REQ-014 sw_sync  output  SW_WIDTH  debounced switch vector.
REQ-015 sw_changed  output  1  one-cycle pulse when sw_sync updates.

Function
REQ-016 SHALL pass each btn_raw and sw_raw bit through a 2-flop synchronizer; no logic SHALL read the first flop.
REQ-017 SHALL keep one debounce counter per button, sized $clog2(DEBOUNCE_CYCLES+1); a cycle where synced value == btn_level clears it, a cycle where it differs increments it.
REQ-018 SHALL invert btn_level[i] and clear its counter on the edge where counter[i] would reach DEBOUNCE_CYCLES, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-019 Latency: a clean raw transition SHALL appear on btn_level exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples it.
REQ-020 btn_press[i] / btn_release[i] SHALL be registered and high exactly in the first cycle of btn_level[i]=1 / =0 respectively; never both in the same cycle.
REQ-021 SHALL run an independent per-button repeat FSM, states IDLE, HOLD, RPT, with a counter sized $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
REQ-022 FSM transitions: IDLE->HOLD with counter=0 in the btn_press cycle; in HOLD the counter counts, and on reaching HOLD_CYCLES it pulses btn_repeat, goes to RPT and sets counter=0; in RPT it pulses every REPEAT_CYCLES cycles.
REQ-023 First btn_repeat SHALL occur HOLD_CYCLES cycles after the btn_press cycle, then at +REPEAT_CYCLES intervals.
REQ-024 Any state -> IDLE in the btn_release cycle; btn_repeat SHALL NOT assert in that cycle even if the count expires simultaneously.
REQ-025 Buttons SHALL be fully independent; simultaneous presses/repeats on several bits in one cycle are legal, with no priority or masking.
REQ-026 Switch bus SHALL be debounced as one vector: a single counter, cleared whenever the synced vector changes from its previous cycle or equals sw_sync, and otherwise incremented.
REQ-027 sw_sync SHALL load the synced vector when that counter reaches DEBOUNCE_CYCLES, with sw_changed high in the same cycle that sw_sync first shows the new value.
REQ-028 Counters SHALL saturate/clear as specified and never wrap; a button held indefinitely SHALL repeat indefinitely.

Reset
REQ-029 While rst_n=0, all synchronizer flops, counters, btn_level, btn_press, btn_release, btn_repeat, sw_sync and sw_changed SHALL be 0 and all FSMs IDLE, asynchronously.
REQ-030 Reset mid-operation SHALL abort all in-progress debounce/repeat with no pulses; a button or switch held through reset SHALL be re-detected as a fresh press/change 2+DEBOUNCE_CYCLES edges after release.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-031 Bounce: btn_raw[0] toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one btn_press[0], 6 edges after settle; no earlier level change.
REQ-032 Glitch: btn_raw[2]=1 for 3 cycles -> btn_level, btn_press and btn_release all stay 0.
REQ-033 Hold: btn_raw[1] held so level stays 1 for 60 cycles -> btn_repeat[1] at press+20, +28, +36, +44, +52; release gives one btn_release[1] and no further repeats.
REQ-034 Simultaneous: btn_raw[0] and btn_raw[4] rise on the same edge -> btn_press=5'b10001 in one cycle.
REQ-035 Switches: sw_raw 0x0000 -> 0xA5C3 -> sw_sync=0xA5C3 after 6 edges, with a single-cycle sw_changed.
REQ-036 Reset in RPT with btn_raw[3] held -> outputs 0 immediately; after release, btn_press[3] at +6 and first repeat 20 cycles later.
